// File: rtl/vga_scope_pkg.sv
// Shared types and defaults for the VGA oscilloscope capture block.
package vga_scope_pkg;

   // Capture/draw sequencer states
   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAW    = 2'd2
   } state_t;

   // Default trace colour (red) and default last column of the sweep
   localparam logic [11:0] DEFAULT_COLOR = 12'hF00;
   localparam int          DEFAULT_X_MAX = 159;

endpackage

// File: rtl/scope_trigger_detect.sv
// Level-crossing trigger detector for the scope capture path.
// Remembers the previous valid sample while armed and pulses trig for one
// cycle on the valid sample that crosses the level in the selected direction.
// Optional build macro VGA_SCOPE_AUTO_TRIG_EN adds an auto-trigger timeout so
// a flat input still produces a capture.
module scope_trigger_detect #(
   parameter int DATA_W = 14,
   parameter int TO_W   = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] level,
   input  logic              rising,
   output logic              trig
);

   logic [DATA_W-1:0] prev;
   logic              have_prev;
   logic              edge_hit;
   logic              timeout;

   // Track the last valid sample; forgotten whenever we are not armed so the
   // first sample after arming can only seed the comparison.
   always_ff @(posedge clk) begin
      if (reset || !active) begin
         prev      <= '0;
         have_prev <= 1'b0;
      end else if (sample_valid) begin
         prev      <= sample_data;
         have_prev <= 1'b1;
      end
   end

   // Direction-dependent crossing test between previous and current sample
   always_comb begin
      edge_hit = 1'b0;
      if (rising)
         edge_hit = (prev < level) && (level <= sample_data);
      else
         edge_hit = (prev >= level) && (level > sample_data);
   end

`ifdef VGA_SCOPE_AUTO_TRIG_EN
   logic [TO_W-1:0] to_cnt;

   // Count armed cycles, saturating at all-ones; restarts on every arming
   always_ff @(posedge clk) begin
      if (reset || !active)
         to_cnt <= '0;
      else if (!timeout)
         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = &to_cnt;
`else
   // No timeout counter: the detector waits for a genuine crossing forever.
   // The zero constant keeps the counter width parameter referenced.
   localparam logic [TO_W-1:0] TO_IDLE = '0;
   assign timeout = |TO_IDLE;
`endif

   assign trig = active && sample_valid && ((have_prev && edge_hit) || timeout);

endmodule

// File: rtl/vga_scope_capture.sv
// Triggered single-channel scope capture and column sweeper for VGA plotting.
// Arms on a level crossing, captures X_MAX+1 decimated samples, then sweeps
// CounterX across the columns presenting the scaled sample on CounterY.
// Optional build macro VGA_SCOPE_AUTO_TRIG_EN enables the auto-trigger timeout
// inside scope_trigger_detect.
module vga_scope_capture
   import vga_scope_pkg::*;
#(
   parameter int          DATA_W = 14,
   parameter int          Y_W    = 8,
   parameter int          X_W    = 8,
   parameter int          X_MAX  = DEFAULT_X_MAX,
   parameter int          DEC_W  = 8,
   parameter logic [11:0] COLOR  = DEFAULT_COLOR,
   parameter int          TO_W   = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic [DEC_W-1:0]  decim,
   input  logic              enable,
   output logic [X_W-1:0]    CounterX,
   output logic [Y_W-1:0]    CounterY,
   output logic [11:0]       color,
   output logic              finished,
   output logic              busy
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);

   state_t state, next_state;

   logic [DATA_W-1:0] level_q;
   logic              rising_q;
   logic [DEC_W-1:0]  decim_q;

   logic [X_W-1:0]    wr_ptr;
   logic [DEC_W-1:0]  dec_cnt;

   // Only the displayed bits of each sample are worth storing
   logic [Y_W-1:0]    mem [0:X_MAX];

   logic              armed;
   logic              trig;
   logic              keep;
   logic              wr_en;
   logic [X_W-1:0]    wr_addr;
   logic              last_write;
   logic              at_last;
   logic              advance;
   logic              rd_en;
   logic [X_W-1:0]    rd_addr;

   assign armed    = (state == ST_ARMED);
   assign at_last  = (CounterX == X_LAST);
   assign finished = (state == ST_DRAW) && at_last;
   assign busy     = (state != ST_DRAW);
   assign color    = COLOR;

   scope_trigger_detect #(
      .DATA_W (DATA_W),
      .TO_W   (TO_W)
   ) u_trig (
      .clk          (clk),
      .reset        (reset),
      .active       (armed),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .level        (level_q),
      .rising       (rising_q),
      .trig         (trig)
   );

   // Buffer write/read control; the read address is prefetched so CounterY
   // lands on the same edge as the CounterX it belongs to
   always_comb begin
      keep       = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      last_write = 1'b0;
      advance    = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      keep       = sample_valid && (dec_cnt == decim_q);
      if (state == ST_ARMED) begin
         wr_en = trig;
      end else if (state == ST_CAPTURE) begin
         wr_en      = keep;
         wr_addr    = wr_ptr;
         last_write = keep && (wr_ptr == X_LAST);
      end
      advance = (state == ST_DRAW) && enable && !at_last;
      rd_en   = last_write || advance;
      if (advance)
         rd_addr = CounterX + 1'b1;
   end

   // Next-state logic for the arm / capture / draw sequence
   always_comb begin
      next_state = state;
      unique case (state)
         ST_ARMED:   if (trig)       next_state = ST_CAPTURE;
         ST_CAPTURE: if (last_write) next_state = ST_DRAW;
         ST_DRAW:    if (at_last)    next_state = ST_ARMED;
         default:                    next_state = ST_ARMED;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_ARMED;
      else
         state <= next_state;
   end

   // Trigger settings are latched whenever the block (re)enters ARMED
   always_ff @(posedge clk) begin
      if (reset || finished) begin
         level_q  <= trig_level;
         rising_q <= trig_rising;
         decim_q  <= decim;
      end
   end

   // Write pointer and decimation counter for the capture phase
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         dec_cnt <= '0;
      end else if (state == ST_ARMED) begin
         if (trig) begin
            wr_ptr  <= X_W'(1);
            dec_cnt <= '0;
         end
      end else if (state == ST_CAPTURE && sample_valid) begin
         if (keep) begin
            dec_cnt <= '0;
            wr_ptr  <= last_write ? '0 : wr_ptr + 1'b1;
         end else begin
            dec_cnt <= dec_cnt + 1'b1;
         end
      end
   end

   // Sample buffer write port
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= sample_data[DATA_W-1 -: Y_W];
   end

   // Column sweep: CounterX and the registered buffer read on CounterY
   always_ff @(posedge clk) begin
      if (reset) begin
         CounterX <= '0;
         CounterY <= '0;
      end else begin
         if (rd_en)
            CounterY <= mem[rd_addr];
         if (last_write || finished)
            CounterX <= '0;
         else if (advance)
            CounterX <= CounterX + 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_scope_capture.sv
// Self-checking bench for vga_scope_capture: randomized sample streams are
// compared against a queue-based model of trigger, decimation and sweep.
module tb_vga_scope_capture;

   localparam int DATA_W = 14;
   localparam int Y_W    = 8;
   localparam int X_W    = 8;
   localparam int X_MAX  = 159;
   localparam int DEC_W  = 8;
   localparam int TO_W   = 12;
   localparam int SHIFT  = DATA_W - Y_W;
   localparam int DMAX   = (1 << DATA_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic [DATA_W-1:0] trig_level;
   logic              trig_rising;
   logic [DEC_W-1:0]  decim;
   logic              enable;
   logic [X_W-1:0]    CounterX;
   logic [Y_W-1:0]    CounterY;
   logic [11:0]       color;
   logic              finished;
   logic              busy;

   vga_scope_capture #(
      .DATA_W (DATA_W),
      .Y_W    (Y_W),
      .X_W    (X_W),
      .X_MAX  (X_MAX),
      .DEC_W  (DEC_W),
      .COLOR  (12'hF00),
      .TO_W   (TO_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .trig_level   (trig_level),
      .trig_rising  (trig_rising),
      .decim        (decim),
      .enable       (enable),
      .CounterX     (CounterX),
      .CounterY     (CounterY),
      .color        (color),
      .finished     (finished),
      .busy         (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [DATA_W-1:0] q [$];
   logic [DATA_W-1:0] exp_buf [0:X_MAX];

   int pend_lvl, pend_dec, cur_lvl, cur_dec;
   bit pend_rise, cur_rise;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      if (obs !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit en);
      sample_valid = v;
      sample_data  = d;
      enable       = en;
      tick();
   endtask

   task automatic setConfig(input int lvl, input bit rise, input int dec);
      pend_lvl    = lvl;
      pend_rise   = rise;
      pend_dec    = dec;
      trig_level  = DATA_W'(lvl);
      trig_rising = rise;
      decim       = DEC_W'(dec);
   endtask

   task automatic latchConfig();
      cur_lvl  = pend_lvl;
      cur_rise = pend_rise;
      cur_dec  = pend_dec;
   endtask

   task automatic doReset(input int cycles);
      reset        = 1'b1;
      sample_valid = 1'b0;
      enable       = 1'b0;
      tick();
      checkOutput("rst_x", CounterX, 0);
      checkOutput("rst_y", CounterY, 0);
      checkOutput("rst_fin", finished, 0);
      checkOutput("rst_busy", busy, 1);
      repeat (cycles - 1) tick();
      latchConfig();
      reset = 1'b0;
   endtask

   function automatic bit crossed(input int p, input int s);
      if (cur_rise) return (p < cur_lvl) && (cur_lvl <= s);
      return (p >= cur_lvl) && (cur_lvl > s);
   endfunction

   function automatic logic [DATA_W-1:0] genSample(input int mode, input int n, input int start, input int step);
      int v;
      v = start + n * step;
      case (mode)
         0:       return DATA_W'($urandom);
         1:       return DATA_W'(v);
         2:       return (v > DMAX) ? DATA_W'(DMAX) : DATA_W'(v);
         default: return DATA_W'(start);
      endcase
   endfunction

   // Feed valid samples while the block is busy; the model finds the trigger
   // as the first crossing pair and derives the stored columns from the queue
   task automatic captureRun(input int mode, input int start, input int step, input int budget,
                             input int stopAfter, output bit reached, output int trig_idx);
      int t;
      int cyc;
      bit v;
      logic [DATA_W-1:0] d;
      t = -1;
      cyc = 0;
      reached = 1'b0;
      q.delete();
      while (cyc < budget) begin
         if (busy !== 1'b1) begin
            reached = 1'b1;
            break;
         end
         if (stopAfter >= 0 && t >= 0 && q.size() >= t + 1 + stopAfter) break;
         v = ($urandom_range(3) != 0);
         if (v) begin
            d = genSample(mode, q.size(), start, step);
            q.push_back(d);
            if (t < 0 && q.size() >= 2 && crossed(int'(q[q.size()-2]), int'(d)))
               t = q.size() - 1;
         end else begin
            d = DATA_W'($urandom);
         end
         applyStimulus(v, d, 1'b0);
         cyc++;
      end
      if (busy === 1'b0) reached = 1'b1;
      sample_valid = 1'b0;
      trig_idx = t;
      if (reached && t >= 0) begin
         checkOutput("capture_len", q.size(), t + X_MAX * (cur_dec + 1) + 1);
         for (int k = 0; k <= X_MAX; k++)
            if (t + k * (cur_dec + 1) < q.size())
               exp_buf[k] = q[t + k * (cur_dec + 1)];
      end
   endtask

   // Sweep the columns with the chosen enable pattern and check every cycle
   task automatic drawRun(input int enMode, input int nlvl, input bit nrise, input int ndec);
      int mx;
      int cyc;
      bit en;
      bit done;
      mx = 0;
      cyc = 0;
      done = 1'b0;
      setConfig(nlvl, nrise, ndec);
      while (!done && cyc < 4 * X_MAX + 400) begin
         checkOutput("draw_busy", busy, 0);
         checkOutput("draw_x", CounterX, mx);
         checkOutput("draw_y", CounterY, exp_buf[mx] >> SHIFT);
         checkOutput("draw_fin", finished, (mx == X_MAX));
         case (enMode)
            0:       en = ($urandom_range(3) != 0);
            1:       en = 1'b1;
            default: en = (cyc % 2 == 0);
         endcase
         applyStimulus(bit'($urandom_range(1)), DATA_W'($urandom), en);
         if (mx == X_MAX) begin
            done = 1'b1;
            if (enMode == 2) checkOutput("toggle_cycles", cyc, 2 * X_MAX - 1);
            checkOutput("rearm_busy", busy, 1);
            checkOutput("rearm_x", CounterX, 0);
            checkOutput("rearm_fin", finished, 0);
            latchConfig();
         end else if (en) begin
            mx++;
         end
         cyc++;
      end
      checkOutput("draw_done", done, 1);
      enable = 1'b0;
   endtask

   initial begin
      bit reached;
      int t;
      int mode, start, step;
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      enable       = 1'b0;
      setConfig(8192, 1'b1, 0);
      doReset(3);
      checkOutput("color", color, 12'hF00);

      // Rising ramp, step 64, level 8192, every sample kept
      captureRun(1, 0, 64, 4000, -1, reached, t);
      checkOutput("ramp_reached", reached, 1);
      checkOutput("ramp_y0", CounterY, 8'h80);
      drawRun(1, 5000, 1'b1, 3);

      // Decimation by 4 on a unit ramp, enable toggling each cycle
      captureRun(1, 4000, 1, 6000, -1, reached, t);
      checkOutput("decim_reached", reached, 1);
      drawRun(2, int'($urandom_range(14335, 2048)), bit'($urandom_range(1)), int'($urandom_range(3)));

      // Randomized data, levels, directions, decimation and enable patterns
      for (int r = 0; r < 6; r++) begin
         mode  = int'($urandom_range(1));
         start = int'($urandom_range(DMAX));
         step  = int'($urandom_range(200, 32));
         captureRun(mode, start, step, 8000, -1, reached, t);
         checkOutput("rand_reached", reached, 1);
         if (r == 5)
            drawRun(int'($urandom_range(2)), 8192, 1'b1, 0);
         else
            drawRun(int'($urandom_range(2)), int'($urandom_range(14335, 2048)),
                    bit'($urandom_range(1)), int'($urandom_range(3)));
      end

      // Reset in the middle of a capture, then recapture fresh data
      captureRun(1, 0, 37, 4000, 80, reached, t);
      checkOutput("mid_busy", busy, 1);
      setConfig(3000, 1'b0, 1);
      doReset(1);
      captureRun(0, 0, 0, 8000, -1, reached, t);
      checkOutput("recap_reached", reached, 1);
      drawRun(1, 8192, 1'b0, 0);

`ifndef VGA_SCOPE_AUTO_TRIG_EN
      // Falling trigger on a rising, saturating ramp never fires
      captureRun(2, 0, 64, 1000, -1, reached, t);
      checkOutput("notrig_reached", reached, 0);
      checkOutput("notrig_busy", busy, 1);
`endif

      // Flat input
      setConfig(500, 1'b1, 0);
      doReset(2);
`ifdef VGA_SCOPE_AUTO_TRIG_EN
      captureRun(3, 1000, 0, 6000, -1, reached, t);
      checkOutput("flat_reached", reached, 1);
      for (int k = 0; k <= X_MAX; k++) exp_buf[k] = DATA_W'(1000);
      checkOutput("flat_y0", CounterY, 15);
      drawRun(1, 500, 1'b1, 0);
`else
      captureRun(3, 1000, 0, 2000, -1, reached, t);
      checkOutput("flat_reached", reached, 0);
      checkOutput("flat_busy", busy, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
